// File: rtl/kayrv_bus_pkg.sv
// Shared types and defaults for the KayRV core-to-memory bus.
package kayrv_bus_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      RESP_NONE  = 2'd0,
      RESP_INSTR = 2'd1,
      RESP_DATA  = 2'd2
   } resp_own_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of IBUS, DBUS and memory-port signals around the memory arbiter.
interface mem_arbiter_if
   import kayrv_bus_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);

   logic              i_iReq;
   logic [ADDR_W-1:0] i_iAddr;
   logic              o_iGnt;
   logic              o_iValid;
   logic [DATA_W-1:0] o_iData;

   logic              i_dReadEn;
   logic              i_dWriteEn;
   logic [ADDR_W-1:0] i_dAddr;
   logic [DATA_W-1:0] i_dWData;
   logic              o_dGnt;
   logic              o_dValid;
   logic [DATA_W-1:0] o_dRData;

   logic              o_Mem_En;
   logic              o_Mem_We;
   logic [ADDR_W-1:0] o_Mem_Addr;
   logic [DATA_W-1:0] o_Mem_WData;
   logic [DATA_W-1:0] i_Mem_RData;

   logic              o_Stall;

   // The arbiter's view.
   modport slave (
      input  i_iReq, i_iAddr, i_dReadEn, i_dWriteEn, i_dAddr, i_dWData, i_Mem_RData,
      output o_iGnt, o_iValid, o_iData, o_dGnt, o_dValid, o_dRData,
      output o_Mem_En, o_Mem_We, o_Mem_Addr, o_Mem_WData, o_Stall
   );

   // The core/memory environment's view.
   modport master (
      output i_iReq, i_iAddr, i_dReadEn, i_dWriteEn, i_dAddr, i_dWData, i_Mem_RData,
      input  o_iGnt, o_iValid, o_iData, o_dGnt, o_dValid, o_dRData,
      input  o_Mem_En, o_Mem_We, o_Mem_Addr, o_Mem_WData, o_Stall
   );

endinterface

// File: rtl/mem_arbiter_arb_prio2.sv
// Two-input fixed-priority arbiter (data over instruction) with an
// instruction-fetch starvation counter.
module arb_prio2 #(
   parameter int MAX_WAIT = 3
) (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic req_i,
   input  logic req_d,
   output logic grant_i,
   output logic grant_d
);

   logic [3:0] wait_cnt;
   logic       force_i;

   assign force_i = (wait_cnt == 4'(MAX_WAIT));

   always_comb begin
      grant_i = req_i & (~req_d | force_i);
      grant_d = req_d & ~grant_i;
   end

   // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         wait_cnt <= 4'd0;
      end else if (req_i & ~grant_i) begin
         wait_cnt <= force_i ? wait_cnt : wait_cnt + 4'd1;
      end else begin
         wait_cnt <= 4'd0;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 1-cycle-latency single-port memory between IBUS and DBUS,
// routing read data back to whichever bus owned the previous access.
module mem_arbiter
   import kayrv_bus_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_WAIT = 3
) (
   input  logic          i_Clk,
   input  logic          i_Rst,
   mem_arbiter_if.slave  bus
);

   logic              req_i;
   logic              req_d;
   logic              grant_i;
   logic              grant_d;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   resp_own_e         resp_own;
   resp_own_e         resp_nxt;

   // Requests are masked during reset so grants, memory port and stall read 0.
   assign req_i = bus.i_iReq & ~i_Rst;
   assign req_d = (bus.i_dReadEn | bus.i_dWriteEn) & ~i_Rst;

   arb_prio2 #(.MAX_WAIT(MAX_WAIT)) u_arb (
      .i_Clk   (i_Clk),
      .i_Rst   (i_Rst),
      .req_i   (req_i),
      .req_d   (req_d),
      .grant_i (grant_i),
      .grant_d (grant_d)
   );

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) resp_own <= RESP_NONE;
      else       resp_own <= resp_nxt;
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      resp_nxt = RESP_NONE;
      if (grant_i)                         resp_nxt = RESP_INSTR;
      else if (grant_d & ~bus.i_dWriteEn)  resp_nxt = RESP_DATA;
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      if (grant_d) begin
         mem_addr  = bus.i_dAddr;
         mem_wdata = bus.i_dWData;
      end else if (grant_i) begin
         mem_addr  = bus.i_iAddr;
      end

      bus.o_iGnt      = grant_i;
      bus.o_dGnt      = grant_d;
      bus.o_Mem_En    = grant_i | grant_d;
      bus.o_Mem_We    = grant_d & bus.i_dWriteEn;
      bus.o_Mem_Addr  = mem_addr;
      bus.o_Mem_WData = mem_wdata;
      bus.o_Stall     = (req_i & ~grant_i) | (req_d & ~grant_d);

      bus.o_iValid    = (resp_own == RESP_INSTR) & ~i_Rst;
      bus.o_dValid    = (resp_own == RESP_DATA)  & ~i_Rst;
      bus.o_iData     = bus.o_iValid ? bus.i_Mem_RData : '0;
      bus.o_dRData    = bus.o_dValid ? bus.i_Mem_RData : '0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed stimulus, a behavioural
// memory, and a response scoreboard checked whenever a valid appears.
module tb_mem_arbiter;
   import kayrv_bus_pkg::*;

   typedef struct {
      resp_own_e   side;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];

   logic [31:0] mem [0:63];

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(3)) dut (
      .i_Clk (clk),
      .i_Rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference contents, independent of the memory model below.
   function automatic logic [31:0] exp_word(input logic [31:0] a);
      return (a == 32'h10) ? 32'hDEADBEEF : (32'hC0DE_0000 | a);
   endfunction

   initial begin
      for (int k = 0; k < 64; k++) mem[k] = exp_word(32'(k * 4));
      bus.i_Mem_RData = '0;
   end

   always @(posedge clk) begin
      if (bus.o_Mem_En) begin
         if (bus.o_Mem_We) mem[bus.o_Mem_Addr[7:2]] <= bus.o_Mem_WData;
         else              bus.i_Mem_RData          <= mem[bus.o_Mem_Addr[7:2]];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.i_iReq     = 1'b0;
      bus.i_iAddr    = '0;
      bus.i_dReadEn  = 1'b0;
      bus.i_dWriteEn = 1'b0;
      bus.i_dAddr    = '0;
      bus.i_dWData   = '0;
   endtask

   task automatic push(input resp_own_e side, input logic [31:0] data);
      exp_t e;
      e.side = side;
      e.data = data;
      sb.push_back(e);
   endtask

   // Scoreboard: every returned response must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && (bus.o_iValid || bus.o_dValid)) begin
         check("dual_valid", 64'(bus.o_iValid & bus.o_dValid), 64'd0);
         if (sb.size() == 0) begin
            check("unexpected_valid", 64'({bus.o_iValid, bus.o_dValid}), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("resp_side", 64'(bus.o_dValid ? RESP_DATA : RESP_INSTR), 64'(e.side));
            check("resp_data", 64'(bus.o_dValid ? bus.o_dRData : bus.o_iData), 64'(e.data));
            check("resp_other_zero", 64'(bus.o_dValid ? bus.o_iData : bus.o_dRData), 64'd0);
         end
      end
   end

   // Requester contract: a denied request and its address stay put until granted.
   logic        i_pend = 1'b0;
   logic        d_pend = 1'b0;
   logic [31:0] i_addr_q = '0;
   logic [31:0] d_addr_q = '0;
   always @(posedge clk) begin
      if (i_pend && !(bus.i_iReq && bus.i_iAddr == i_addr_q))
         $error("IBUS request changed before grant");
      if (d_pend && !((bus.i_dReadEn || bus.i_dWriteEn) && bus.i_dAddr == d_addr_q))
         $error("DBUS request changed before grant");
      i_pend   <= !rst && bus.i_iReq && !bus.o_iGnt;
      d_pend   <= !rst && (bus.i_dReadEn || bus.i_dWriteEn) && !bus.o_dGnt;
      i_addr_q <= bus.i_iAddr;
      d_addr_q <= bus.i_dAddr;
   end

   initial begin
      idle();
      bus.i_iReq    = 1'b1;
      bus.i_dReadEn = 1'b1;
      #12;
      check("rst_igrant", 64'(bus.o_iGnt), 64'd0);
      check("rst_dgrant", 64'(bus.o_dGnt), 64'd0);
      check("rst_stall",  64'(bus.o_Stall), 64'd0);
      check("rst_mem_en", 64'(bus.o_Mem_En), 64'd0);
      check("rst_ivalid", 64'(bus.o_iValid), 64'd0);
      idle();
      step();
      rst = 1'b0;

      // IBUS-only fetch
      bus.i_iReq = 1'b1; bus.i_iAddr = 32'h10;
      push(RESP_INSTR, 32'hDEADBEEF);
      #3;
      check("f_igrant",   64'(bus.o_iGnt), 64'd1);
      check("f_mem_addr", 64'(bus.o_Mem_Addr), 64'h10);
      check("f_mem_we",   64'(bus.o_Mem_We), 64'd0);
      check("f_stall0",   64'(bus.o_Stall), 64'd0);
      step(); idle(); #3;
      check("f_ivalid",   64'(bus.o_iValid), 64'd1);
      check("f_idata",    64'(bus.o_iData), 64'hDEADBEEF);
      check("f_stall1",   64'(bus.o_Stall), 64'd0);
      step();

      // Write/read collision
      bus.i_dWriteEn = 1'b1; bus.i_dAddr = 32'h20; bus.i_dWData = 32'h1234;
      bus.i_iReq = 1'b1; bus.i_iAddr = 32'h14;
      #3;
      check("c_dgrant",   64'(bus.o_dGnt), 64'd1);
      check("c_igrant",   64'(bus.o_iGnt), 64'd0);
      check("c_mem_we",   64'(bus.o_Mem_We), 64'd1);
      check("c_mem_addr", 64'(bus.o_Mem_Addr), 64'h20);
      check("c_wdata",    64'(bus.o_Mem_WData), 64'h1234);
      check("c_stall",    64'(bus.o_Stall), 64'd1);
      step();
      bus.i_dWriteEn = 1'b0; bus.i_dAddr = '0; bus.i_dWData = '0;
      push(RESP_INSTR, exp_word(32'h14));
      #3;
      check("c_igrant2",  64'(bus.o_iGnt), 64'd1);
      check("c_no_dvalid", 64'(bus.o_dValid), 64'd0);
      step();
      idle();
      bus.i_dReadEn = 1'b1; bus.i_dAddr = 32'h20;
      push(RESP_DATA, 32'h1234);
      #3;
      check("c_dgrant_rd", 64'(bus.o_dGnt), 64'd1);
      step(); idle(); #3;
      check("c_dvalid",   64'(bus.o_dValid), 64'd1);
      check("c_drdata",   64'(bus.o_dRData), 64'h1234);
      step();

      // Starvation guard with continuous DBUS reads
      bus.i_iReq = 1'b1; bus.i_iAddr = 32'h18;
      for (int c = 0; c < 4; c++) begin
         bus.i_dReadEn = 1'b1; bus.i_dAddr = 32'(c * 4);
         #3;
         check("s_stall", 64'(bus.o_Stall), 64'd1);
         if (c < 3) begin
            check("s_idenied", 64'(bus.o_iGnt), 64'd0);
            check("s_dgrant",  64'(bus.o_dGnt), 64'd1);
            push(RESP_DATA, exp_word(32'(c * 4)));
         end else begin
            check("s_iforced", 64'(bus.o_iGnt), 64'd1);
            check("s_ddenied", 64'(bus.o_dGnt), 64'd0);
            push(RESP_INSTR, exp_word(32'h18));
         end
         step();
      end
      bus.i_iAddr = 32'h1C;
      #3;
      check("s_cnt_clear_i", 64'(bus.o_iGnt), 64'd0);
      check("s_cnt_clear_d", 64'(bus.o_dGnt), 64'd1);
      push(RESP_DATA, exp_word(32'hC));
      step();
      bus.i_dReadEn = 1'b0;
      #3;
      check("s_ialone", 64'(bus.o_iGnt), 64'd1);
      push(RESP_INSTR, exp_word(32'h1C));
      step(); idle(); step();

      // Back-to-back alternating reads
      bus.i_iReq = 1'b1; bus.i_iAddr = 32'h0;
      push(RESP_INSTR, exp_word(32'h0));
      #3; check("b_g0", 64'({bus.o_iGnt, bus.o_dGnt}), 64'b10);
      step(); idle();
      bus.i_dReadEn = 1'b1; bus.i_dAddr = 32'h4;
      push(RESP_DATA, exp_word(32'h4));
      #3; check("b_g1", 64'({bus.o_iGnt, bus.o_dGnt}), 64'b01);
      check("b_v1", 64'({bus.o_iValid, bus.o_dValid}), 64'b10);
      step(); idle();
      bus.i_iReq = 1'b1; bus.i_iAddr = 32'h8;
      push(RESP_INSTR, exp_word(32'h8));
      #3; check("b_g2", 64'({bus.o_iGnt, bus.o_dGnt}), 64'b10);
      check("b_v2", 64'({bus.o_iValid, bus.o_dValid}), 64'b01);
      step(); idle(); #3;
      check("b_v3", 64'({bus.o_iValid, bus.o_dValid}), 64'b10);
      step();

      // Both enables set: treated as a write
      bus.i_dReadEn = 1'b1; bus.i_dWriteEn = 1'b1;
      bus.i_dAddr = 32'h30; bus.i_dWData = 32'h5555AAAA;
      #3;
      check("w2_we",   64'(bus.o_Mem_We), 64'd1);
      check("w2_gnt",  64'(bus.o_dGnt), 64'd1);
      step(); idle(); #3;
      check("w2_no_dvalid", 64'(bus.o_dValid), 64'd0);
      step();
      bus.i_dReadEn = 1'b1; bus.i_dAddr = 32'h30;
      push(RESP_DATA, 32'h5555AAAA);
      step(); idle(); step();

      // Reset in the cycle after an IBUS grant
      bus.i_iReq = 1'b1; bus.i_iAddr = 32'h24;
      #3; check("r_igrant", 64'(bus.o_iGnt), 64'd1);
      @(posedge clk); #1;
      idle();
      check("r_ivalid_pre", 64'(bus.o_iValid), 64'd1);
      #1 rst = 1'b1;
      #1;
      bus.i_iReq = 1'b1; bus.i_dReadEn = 1'b1; bus.i_dWriteEn = 1'b1; bus.i_dAddr = 32'h4;
      #1;
      check("r_ivalid", 64'(bus.o_iValid), 64'd0);
      check("r_idata",  64'(bus.o_iData), 64'd0);
      check("r_gnts",   64'({bus.o_iGnt, bus.o_dGnt}), 64'd0);
      check("r_stall",  64'(bus.o_Stall), 64'd0);
      check("r_mem",    64'({bus.o_Mem_En, bus.o_Mem_We}), 64'd0);
      check("r_maddr",  64'(bus.o_Mem_Addr), 64'd0);
      step(); step();
      idle();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #3;
         check("r_post_valid", 64'({bus.o_iValid, bus.o_dValid}), 64'd0);
         check("r_post_stall", 64'(bus.o_Stall), 64'd0);
         step();
      end

      step();
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
